// File: rtl/warmboot_pkg.sv
// Shared definitions for the warmboot controller: state encodings,
// default image index and 48 MHz cycle constants.
// No logic; constants only.
package warmboot_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        IDLE      = 2'd1,
        DRAIN     = 2'd2,
        FIRE      = 2'd3
    } wb_state_t;

    localparam logic [1:0]  IMAGE_SEL_DEF = 2'b01;

    // 10 ms and 10 s at 48 MHz
    localparam logic [31:0] CYC_10MS = 32'd480_000;
    localparam logic [31:0] CYC_10S  = 32'd480_000_000;

endpackage

// File: rtl/warmboot_ctrl_cycle_timer.sv
// Loadable down-counter with a zero flag, used to time the USB drain window.
// Latency: load/clear take effect on the next clock; zero flag is combinational from the count.
// Backpressure: none; decrement saturates at zero.
module cycle_timer #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] count_q;

    // Clear beats load beats decrement; never wraps below zero
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_q <= count_q - W'(1);
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/warmboot_ctrl.sv
// Sequences the iCE40 warmboot: waits for PLL lock, drains USB, then fires BOOT.
// Latency: DRAIN lasts DRAIN_CYCLES; BOOT rises on the first FIRE cycle; all outputs registered.
// Backpressure: none; boot_req is latched as a pending request, FIRE is terminal until reset.
module warmboot_ctrl
    import warmboot_pkg::*;
#(
    parameter logic [1:0]  IMAGE_SEL       = IMAGE_SEL_DEF,
    parameter logic [31:0] DRAIN_CYCLES    = CYC_10MS,
    parameter logic [31:0] AUTOBOOT_CYCLES = CYC_10S
) (
    input  logic       clk_48mhz,
    input  logic       reset,
    input  logic       pll_lock,
    input  logic       boot_req,
    input  logic       usb_activity,
    output logic       wb_s1,
    output logic       wb_s0,
    output logic       wb_boot,
    output logic       host_seen,
    output logic [1:0] state_dbg
);

    localparam logic [31:0] DRAIN_LOAD    = DRAIN_CYCLES - 32'd1;
    localparam logic [31:0] AUTOBOOT_LAST = AUTOBOOT_CYCLES - 32'd1;

    logic [1:0]  rst_sync_q;
    logic        rst_int;
    logic        lock_meta_q;
    logic        lock_sync_q;
    wb_state_t   state_q;
    logic        wb_boot_q;
    logic        req_pend_q;
    logic        host_seen_q;
    logic [31:0] idle_cnt_q;
    logic [1:0]  wb_sel_q;

    logic        autoboot_hit;
    logic        go_drain;
    logic        tmr_clr;
    logic        tmr_load;
    logic        tmr_dec;
    logic        tmr_zero;

    // Reset asserts immediately, releases two clocks later in the clk_48mhz domain
    always_ff @(posedge clk_48mhz or posedge reset) begin
        if (reset) begin
            rst_sync_q <= 2'b11;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b0};
        end
    end

    assign rst_int = rst_sync_q[1];

    // Two-flop synchroniser for the asynchronous PLL lock
    always_ff @(posedge clk_48mhz or posedge rst_int) begin
        if (rst_int) begin
            lock_meta_q <= 1'b0;
            lock_sync_q <= 1'b0;
        end else begin
            lock_meta_q <= pll_lock;
            lock_sync_q <= lock_meta_q;
        end
    end

    // Unattended boot only while no host has spoken; a same-cycle token cancels it
    assign autoboot_hit = (AUTOBOOT_CYCLES != 32'd0) && !host_seen_q && !usb_activity &&
                          (idle_cnt_q == AUTOBOOT_LAST);
    assign go_drain     = req_pend_q || autoboot_hit;

    // Drain timer: loaded on IDLE->DRAIN, counted in DRAIN, cleared on lock loss
    always_comb begin
        tmr_clr  = 1'b0;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        if ((state_q == IDLE) || (state_q == DRAIN)) begin
            tmr_clr = !lock_sync_q;
        end
        if ((state_q == IDLE) && lock_sync_q && go_drain) begin
            tmr_load = 1'b1;
        end
        if ((state_q == DRAIN) && lock_sync_q) begin
            tmr_dec = 1'b1;
        end
    end

    cycle_timer #(
        .W (32)
    ) u_drain_timer (
        .clk_i      (clk_48mhz),
        .rst_i      (rst_int),
        .clr_i      (tmr_clr),
        .load_i     (tmr_load),
        .load_val_i (DRAIN_LOAD),
        .dec_i      (tmr_dec),
        .zero_o     (tmr_zero)
    );

    // Main boot sequencer with sticky flags, idle counter and registered outputs
    always_ff @(posedge clk_48mhz or posedge rst_int) begin
        if (rst_int) begin
            state_q     <= WAIT_LOCK;
            wb_boot_q   <= 1'b0;
            req_pend_q  <= 1'b0;
            host_seen_q <= 1'b0;
            idle_cnt_q  <= '0;
            wb_sel_q    <= IMAGE_SEL;
        end else begin
            wb_sel_q <= IMAGE_SEL;
            if (boot_req && (state_q != FIRE)) begin
                req_pend_q <= 1'b1;
            end
            if (usb_activity) begin
                host_seen_q <= 1'b1;
            end
            case (state_q)
                WAIT_LOCK: begin
                    idle_cnt_q <= '0;
                    if (lock_sync_q) begin
                        state_q <= IDLE;
                    end
                end
                IDLE: begin
                    if (!lock_sync_q) begin
                        state_q    <= WAIT_LOCK;
                        idle_cnt_q <= '0;
                    end else if (go_drain) begin
                        state_q    <= DRAIN;
                        idle_cnt_q <= '0;
                    end else if (usb_activity) begin
                        idle_cnt_q <= '0;
                    end else if (!host_seen_q && (idle_cnt_q != '1)) begin
                        idle_cnt_q <= idle_cnt_q + 32'd1;
                    end
                end
                DRAIN: begin
                    idle_cnt_q <= '0;
                    if (!lock_sync_q) begin
                        state_q <= WAIT_LOCK;
                    end else if (tmr_zero) begin
                        state_q   <= FIRE;
                        wb_boot_q <= 1'b1;
                    end
                end
                FIRE: begin
                    wb_boot_q <= 1'b1;
                end
                default: begin
                    state_q <= WAIT_LOCK;
                end
            endcase
        end
    end

    assign wb_s1     = wb_sel_q[1];
    assign wb_s0     = wb_sel_q[0];
    assign wb_boot   = wb_boot_q;
    assign host_seen = host_seen_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_warmboot_ctrl.sv
module tb_warmboot_ctrl;

    logic       clk_48mhz = 1'b0;
    logic       reset;
    logic       pll_lock;
    logic       boot_req;
    logic       usb_activity;

    logic       s1, s0, boot, seen;
    logic [1:0] st;
    logic       s1z, s0z, bootz, seenz;
    logic [1:0] stz;

    int total = 0;
    int bad   = 0;

    always #5 clk_48mhz = ~clk_48mhz;

    warmboot_ctrl #(
        .IMAGE_SEL       (2'b01),
        .DRAIN_CYCLES    (32'd8),
        .AUTOBOOT_CYCLES (32'd100)
    ) dut (
        .clk_48mhz    (clk_48mhz),
        .reset        (reset),
        .pll_lock     (pll_lock),
        .boot_req     (boot_req),
        .usb_activity (usb_activity),
        .wb_s1        (s1),
        .wb_s0        (s0),
        .wb_boot      (boot),
        .host_seen    (seen),
        .state_dbg    (st)
    );

    warmboot_ctrl #(
        .IMAGE_SEL       (2'b01),
        .DRAIN_CYCLES    (32'd8),
        .AUTOBOOT_CYCLES (32'd0)
    ) dut0 (
        .clk_48mhz    (clk_48mhz),
        .reset        (reset),
        .pll_lock     (pll_lock),
        .boot_req     (boot_req),
        .usb_activity (usb_activity),
        .wb_s1        (s1z),
        .wb_s0        (s0z),
        .wb_boot      (bootz),
        .host_seen    (seenz),
        .state_dbg    (stz)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_48mhz);
        #1;
    endtask

    task automatic wait_state(input string tag, input logic [1:0] exp, input int max);
        int n;
        n = 0;
        while (st !== exp && n < max) begin
            tick();
            n++;
        end
        check(tag, {30'd0, st}, {30'd0, exp});
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        pll_lock     = 1'b0;
        boot_req     = 1'b0;
        usb_activity = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        repeat (3) tick();
    endtask

    // Entered on the first DRAIN sample: expects 8 DRAIN cycles then FIRE
    task automatic drain_and_fire(input string tag);
        for (int i = 0; i < 8; i++) begin
            check({tag, "_drain_st"}, {30'd0, st}, 32'd2);
            check({tag, "_drain_boot"}, {31'd0, boot}, 32'd0);
            tick();
        end
        check({tag, "_fire_st"}, {30'd0, st}, 32'd3);
        check({tag, "_fire_boot"}, {31'd0, boot}, 32'd1);
        check({tag, "_fire_sel"}, {30'd0, s1, s0}, 32'd1);
    endtask

    initial begin
        // Reset state
        reset        = 1'b1;
        pll_lock     = 1'b0;
        boot_req     = 1'b0;
        usb_activity = 1'b0;
        repeat (3) tick();
        check("rst_state", {30'd0, st}, 32'd0);
        check("rst_boot", {31'd0, boot}, 32'd0);
        check("rst_seen", {31'd0, seen}, 32'd0);
        check("rst_sel", {30'd0, s1, s0}, 32'd1);
        reset = 1'b0;
        repeat (3) tick();
        check("nolock_state", {30'd0, st}, 32'd0);

        // Explicit boot request
        pll_lock = 1'b1;
        wait_state("t1_idle", 2'd1, 10);
        boot_req = 1'b1;
        tick();
        boot_req = 1'b0;
        check("t1_pend_idle", {30'd0, st}, 32'd1);
        tick();
        drain_and_fire("t1");
        pll_lock = 1'b0;
        repeat (5) tick();
        check("t1_lockloss_fire_st", {30'd0, st}, 32'd3);
        check("t1_lockloss_fire_boot", {31'd0, boot}, 32'd1);

        // Autoboot: 100 IDLE + 8 DRAIN cycles after IDLE entry
        do_reset();
        pll_lock = 1'b1;
        wait_state("t2_idle", 2'd1, 10);
        for (int i = 1; i <= 108; i++) begin
            tick();
            if (i == 99)  check("t2_idle_99", {30'd0, st}, 32'd1);
            if (i == 100) check("t2_drain_100", {30'd0, st}, 32'd2);
            if (i == 107) check("t2_boot_107", {31'd0, boot}, 32'd0);
        end
        check("t2_boot_108", {31'd0, boot}, 32'd1);
        check("t2_fire_108", {30'd0, st}, 32'd3);

        // Host activity cancels autoboot, later request still fires
        do_reset();
        pll_lock = 1'b1;
        wait_state("t3_idle", 2'd1, 10);
        repeat (50) tick();
        usb_activity = 1'b1;
        tick();
        usb_activity = 1'b0;
        check("t3_seen", {31'd0, seen}, 32'd1);
        repeat (10000) tick();
        check("t3_noboot", {31'd0, boot}, 32'd0);
        check("t3_still_idle", {30'd0, st}, 32'd1);
        boot_req = 1'b1;
        tick();
        boot_req = 1'b0;
        tick();
        drain_and_fire("t3");

        // Request while unlocked, lock loss in DRAIN, relock
        do_reset();
        boot_req = 1'b1;
        tick();
        boot_req = 1'b0;
        repeat (20) tick();
        check("t4_unlocked_st", {30'd0, st}, 32'd0);
        check("t4_unlocked_boot", {31'd0, boot}, 32'd0);
        pll_lock = 1'b1;
        wait_state("t4_idle", 2'd1, 10);
        tick();
        check("t4_drain", {30'd0, st}, 32'd2);
        repeat (3) tick();
        pll_lock = 1'b0;
        wait_state("t4_back_wait", 2'd0, 6);
        check("t4_back_boot", {31'd0, boot}, 32'd0);
        pll_lock = 1'b1;
        wait_state("t4_reidle", 2'd1, 10);
        tick();
        drain_and_fire("t4");

        // Reset mid-DRAIN prevents the fire
        do_reset();
        pll_lock = 1'b1;
        wait_state("t5_idle", 2'd1, 10);
        usb_activity = 1'b1;
        tick();
        usb_activity = 1'b0;
        boot_req = 1'b1;
        tick();
        boot_req = 1'b0;
        tick();
        check("t5_drain", {30'd0, st}, 32'd2);
        check("t5_seen_before", {31'd0, seen}, 32'd1);
        repeat (3) tick();
        reset = 1'b1;
        #1;
        check("t5_async_st", {30'd0, st}, 32'd0);
        check("t5_async_boot", {31'd0, boot}, 32'd0);
        check("t5_async_seen", {31'd0, seen}, 32'd0);
        pll_lock = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        repeat (50) tick();
        check("t5_after_st", {30'd0, st}, 32'd0);
        check("t5_after_boot", {31'd0, boot}, 32'd0);
        check("t5_after_seen", {31'd0, seen}, 32'd0);

        // Autoboot disabled instance
        do_reset();
        pll_lock = 1'b1;
        wait_state("t6_idle", 2'd1, 10);
        check("t6_z_idle", {30'd0, stz}, 32'd1);
        repeat (10000) tick();
        check("t6_z_noboot", {31'd0, bootz}, 32'd0);
        check("t6_z_still_idle", {30'd0, stz}, 32'd1);
        boot_req     = 1'b1;
        usb_activity = 1'b1;
        tick();
        boot_req     = 1'b0;
        usb_activity = 1'b0;
        check("t6_z_seen", {31'd0, seenz}, 32'd1);
        tick();
        check("t6_z_drain", {30'd0, stz}, 32'd2);
        repeat (7) tick();
        check("t6_z_drain_last", {30'd0, stz}, 32'd2);
        check("t6_z_boot_pre", {31'd0, bootz}, 32'd0);
        tick();
        check("t6_z_fire", {30'd0, stz}, 32'd3);
        check("t6_z_boot", {31'd0, bootz}, 32'd1);
        check("t6_z_sel", {30'd0, s1z, s0z}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/warmboot_ctrl.md
WARMBOOT_CTRL -- requirements
Module: warmboot_ctrl

Interface
REQ-001 SHALL have parameter IMAGE_SEL, default 2'b01, the warmboot image index driven on wb_s1/wb_s0.
REQ-002 SHALL have parameter DRAIN_CYCLES, default 480000, the delay from boot request to fire (10 ms at 48 MHz) so the final USB handshake completes.
REQ-003 SHALL have parameter AUTOBOOT_CYCLES, default 32'd480000000, the idle time before an unattended boot (10 s); a value of 0 disables autoboot.
REQ-004 clk_48mhz  in  1  sole clock; the 48 MHz PLL global output.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 pll_lock  in  1  PLL LOCK; asynchronous, double-synchronised internally.
REQ-007 boot_req  in  1  boot request from tinyfpga_bootloader; a level, sampled every cycle.
REQ-008 usb_activity  in  1  single-cycle pulse on any valid USB token received.
REQ-009 wb_s1, wb_s0  out  1 each  image select to SB_WARMBOOT.
REQ-010 wb_boot  out  1  SB_WARMBOOT BOOT strobe.
REQ-011 host_seen  out  1  sticky flag: USB activity observed since reset.
REQ-012 state_dbg  out  2  current state encoding.

Function
REQ-013 SHALL implement four states: WAIT_LOCK=0, IDLE=1, DRAIN=2, FIRE=3.
REQ-014 WAIT_LOCK SHALL go to IDLE on the first cycle the synchronised lock reads 1.
REQ-015 IDLE SHALL go to DRAIN when req_pend=1, or when host_seen=0, AUTOBOOT_CYCLES!=0 and the idle counter equals AUTOBOOT_CYCLES-1.
REQ-016 req_pend SHALL set on any cycle boot_req=1, in any state except FIRE, and clear only on reset.
REQ-017 DRAIN SHALL load its counter with DRAIN_CYCLES-1 on entry, decrement each cycle, and go to FIRE on the cycle the count is 0.
REQ-018 Timing: DRAIN lasts exactly DRAIN_CYCLES cycles; wb_boot rises on the first FIRE cycle.
REQ-019 FIRE SHALL be terminal: wb_boot is held at 1 until reset.
REQ-020 wb_s1/wb_s0 SHALL equal IMAGE_SEL in every state and be registered.
REQ-021 The idle counter SHALL count only in IDLE with host_seen=0, clear on leaving IDLE, and never wrap; it is 32 bits wide.
REQ-022 A usb_activity pulse SHALL set host_seen and clear the idle counter in the same cycle, cancelling autoboot until reset.
REQ-023 When boot_req and usb_activity coincide in IDLE, the state SHALL go to DRAIN; the request wins.
REQ-024 Loss of the synchronised lock in IDLE or DRAIN SHALL return to WAIT_LOCK and clear the counters; req_pend and host_seen are retained.
REQ-025 Loss of the synchronised lock in FIRE SHALL be ignored.
REQ-026 boot_req deasserting during DRAIN SHALL NOT abort the boot.
REQ-027 All outputs SHALL be registered; there are no combinational paths from inputs to outputs.

Reset
REQ-028 Asynchronous assertion SHALL force, within the same instant: state=WAIT_LOCK, wb_boot=0, host_seen=0, req_pend=0, counters=0, lock synchroniser=0.
REQ-029 wb_s1/wb_s0 SHALL reset to IMAGE_SEL.
REQ-030 Reset asserted mid-DRAIN SHALL prevent the fire.
REQ-031 Release of reset SHALL be synchronous to clk_48mhz via a two-flop release synchroniser.

Structure
REQ-032 Package warmboot_pkg SHALL hold the state encodings, the default IMAGE_SEL and the 48 MHz cycle constants (CYC_10MS, CYC_10S).
REQ-033 One sub-module, cycle_timer (loadable down-counter with zero flag), SHALL be used for DRAIN.
REQ-034 The idle counter SHALL be inline.
REQ-035 The top level SHALL instantiate SB_WARMBOOT outside this block; this block contains no vendor primitives.

Verification (DRAIN_CYCLES=8, AUTOBOOT_CYCLES=100 unless noted)
REQ-036 lock=1 at cycle 3, boot_req pulse at cycle 10 -> state_dbg 2 for exactly 8 cycles, wb_boot=1 from the 9th cycle on, wb_s1/wb_s0=01 throughout.
REQ-037 lock=1, no stimulus -> wb_boot rises exactly 100 IDLE cycles + 8 DRAIN cycles after entering IDLE.
REQ-038 usb_activity at IDLE cycle 50 -> host_seen=1, no fire after 10000 cycles; a later boot_req then fires after 8 cycles.
REQ-039 boot_req asserted while lock=0 -> no fire; lock rises -> fire 8 cycles after IDLE entry; lock drop in DRAIN -> return to WAIT_LOCK, fire after relock.
REQ-040 reset pulse at DRAIN cycle 4 -> wb_boot stays 0, state_dbg=0, host_seen=0.
REQ-041 AUTOBOOT_CYCLES=0, idle 10000 cycles -> no fire; boot_req and usb_activity in the same cycle -> DRAIN entered, fire occurs.
